// File: rtl/gearbox_pkg.sv
// Shared gear encoding, sequencer state codes and shadow-gearbox transition rules.
package gearbox_pkg;

    localparam logic [3:0] P_STATE = 4'd0;
    localparam logic [3:0] R_STATE = 4'd1;
    localparam logic [3:0] N_STATE = 4'd2;
    localparam logic [3:0] G1      = 4'd3;
    localparam logic [3:0] G2      = 4'd4;
    localparam logic [3:0] G3      = 4'd5;
    localparam logic [3:0] G4      = 4'd6;
    localparam logic [3:0] G5      = 4'd7;
    localparam logic [3:0] G6      = 4'd8;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_CLUTCH_WAIT = 3'd1;
    localparam logic [2:0] ST_SHIFT       = 3'd2;
    localparam logic [2:0] ST_SETTLE      = 3'd3;
    localparam logic [2:0] ST_RELEASE     = 3'd4;
    localparam logic [2:0] ST_FAULT       = 3'd5;

    // Returns the gear after a request; an illegal request returns pos unchanged.
    function automatic logic [3:0] next_gear(input logic [3:0] pos, input logic up,
                                             input logic dn, input logic brake);
        logic [3:0] nxt;
        nxt = pos;
        if (up && !dn) begin
            if ((pos == P_STATE || pos == R_STATE) && brake) begin
                nxt = pos + 4'd1;
            end else if (pos >= N_STATE && pos <= G5) begin
                nxt = pos + 4'd1;
            end
        end else if (dn && !up) begin
            if (pos == N_STATE && brake) begin
                nxt = R_STATE;
            end else if (pos >= G1 && pos <= G6) begin
                nxt = pos - 4'd1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a consecutive-sample debounce counter.
module input_debouncer #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_raw,
    output logic o_level
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    // Synchronize the raw input, then change level after DEB_CYCLES disagreeing samples.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt >= CNT_W'(DEB_CYCLES - 1)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/gear_shift_sequencer.sv
// Paddle/brake conditioning, legality check and clutch handshake for gear shifts.
module gear_shift_sequencer
    import gearbox_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = 4,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned ACK_TIMEOUT   = 16,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic       i_brake,
    input  logic       i_clutch_ack,
    output logic       o_clutch_req,
    output logic       o_shift_up,
    output logic       o_shift_down,
    output logic       o_brake_out,
    output logic [3:0] o_gear_pos,
    output logic       o_busy,
    output logic       o_fault
);

    logic             w_deb_up;
    logic             w_deb_dn;
    logic             w_deb_brake;
    logic             r_up_d;
    logic             r_dn_d;
    logic             w_req_up;
    logic             w_req_dn;
    logic             w_legal;
    logic [3:0]       w_target;
    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_dir_up;
    logic             r_brake_lat;
    logic [3:0]       r_gear;

    input_debouncer #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_up (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_raw(i_btn_up), .o_level(w_deb_up)
    );
    input_debouncer #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_dn (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_raw(i_btn_down), .o_level(w_deb_dn)
    );
    input_debouncer #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_brake (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_raw(i_brake), .o_level(w_deb_brake)
    );

    assign w_req_up  = w_deb_up & ~r_up_d;
    assign w_req_dn  = w_deb_dn & ~r_dn_d;
    assign w_target  = next_gear(r_gear, w_req_up, w_req_dn, w_deb_brake);
    // Simultaneous requests are dropped; an unchanged target means the shift is illegal.
    assign w_legal   = (w_req_up ^ w_req_dn) && (w_target != r_gear);
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    // Next-state and counter logic for the clutch handshake.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_legal) begin
                    w_state_next = ST_CLUTCH_WAIT;
                    w_cnt_next   = '0;
                end
            end
            ST_CLUTCH_WAIT: begin
                if (i_clutch_ack) begin
                    w_state_next = ST_SHIFT;
                    w_cnt_next   = '0;
                end else if (w_cnt_inc >= CNT_W'(ACK_TIMEOUT)) begin
                    w_state_next = ST_FAULT;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            ST_SHIFT: begin
                w_state_next = ST_SETTLE;
                w_cnt_next   = '0;
            end
            ST_SETTLE: begin
                if (w_cnt_inc >= CNT_W'(SETTLE_CYCLES)) begin
                    w_state_next = ST_RELEASE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            ST_RELEASE: begin
                if (!i_clutch_ack) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (w_cnt_inc >= CNT_W'(ACK_TIMEOUT)) begin
                    w_state_next = ST_FAULT;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            ST_FAULT: begin
                w_state_next = ST_FAULT;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // State, edge-detect history, latched request and shadow gear registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_up_d      <= 1'b0;
            r_dn_d      <= 1'b0;
            r_dir_up    <= 1'b0;
            r_brake_lat <= 1'b0;
            r_gear      <= P_STATE;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_up_d  <= w_deb_up;
            r_dn_d  <= w_deb_dn;
            if (r_state == ST_IDLE && w_legal) begin
                r_dir_up    <= w_req_up;
                r_brake_lat <= w_deb_brake;
            end
            // Shadow gear moves on the same edge the gearbox samples the shift pulse.
            if (r_state == ST_SHIFT) begin
                r_gear <= next_gear(r_gear, r_dir_up, ~r_dir_up, r_brake_lat);
            end
        end
    end

    assign o_clutch_req = (r_state == ST_CLUTCH_WAIT) || (r_state == ST_SHIFT) ||
                          (r_state == ST_SETTLE);
    assign o_shift_up   = (r_state == ST_SHIFT) && r_dir_up;
    assign o_shift_down = (r_state == ST_SHIFT) && !r_dir_up;
    assign o_brake_out  = (r_state == ST_SHIFT) ? r_brake_lat : w_deb_brake;
    assign o_gear_pos   = r_gear;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_fault      = (r_state == ST_FAULT);

endmodule

// File: tb/tb_gear_shift_sequencer.sv
// Directed bench for gear_shift_sequencer.
module tb_gear_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_up;
    logic       btn_down;
    logic       brake;
    logic       clutch_ack;
    logic       clutch_req;
    logic       shift_up;
    logic       shift_down;
    logic       brake_out;
    logic [3:0] gear_pos;
    logic       busy;
    logic       fault;

    int errors = 0;
    int checks = 0;

    gear_shift_sequencer #(
        .DEB_CYCLES(4), .SETTLE_CYCLES(8), .ACK_TIMEOUT(16), .CNT_W(8)
    ) dut (
        .i_clk(clk),
        .i_reset_n(reset_n),
        .i_btn_up(btn_up),
        .i_btn_down(btn_down),
        .i_brake(brake),
        .i_clutch_ack(clutch_ack),
        .o_clutch_req(clutch_req),
        .o_shift_up(shift_up),
        .o_shift_down(shift_down),
        .o_brake_out(brake_out),
        .o_gear_pos(gear_pos),
        .o_busy(busy),
        .o_fault(fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; btn_up = 1'b0; btn_down = 1'b0; brake = 1'b0; clutch_ack = 1'b0;
        #12;
        checks++;
        if ({clutch_req, shift_up, shift_down, brake_out, busy, fault} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {clutch_req, shift_up, shift_down, brake_out, busy, fault});
        end
        checks++;
        if (gear_pos !== 4'd0) begin
            errors++; $display("FAIL reset_gear: got %0d expected 0", gear_pos);
        end
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_up_without_brake();
        bit seen;
        seen = 1'b0;
        brake = 1'b0;
        repeat (10) tick();
        btn_up = 1'b1;
        repeat (20) begin
            tick();
            if (clutch_req || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL no_brake_up: got activity=%0d expected 0", seen);
        end
        checks++;
        if (gear_pos !== 4'd0) begin
            errors++; $display("FAIL no_brake_gear: got %0d expected 0", gear_pos);
        end
        btn_up = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_first_shift();
        int n;
        int hi;
        brake = 1'b1;
        repeat (10) tick();
        btn_up = 1'b1;
        n = 0;
        while (!clutch_req && n < 20) begin
            tick(); n++;
        end
        checks++;
        if (n !== 7) begin
            errors++; $display("FAIL req_latency: got %0d cycles expected 7", n);
        end
        tick();
        tick();
        clutch_ack = 1'b1;
        tick();
        checks++;
        if ({shift_up, shift_down, brake_out} !== 3'b101) begin
            errors++;
            $display("FAIL shift_pulse: got up/dn/brk=%b expected 101",
                     {shift_up, shift_down, brake_out});
        end
        checks++;
        if (gear_pos !== 4'd0) begin
            errors++; $display("FAIL gear_before_edge: got %0d expected 0", gear_pos);
        end
        hi = 4;
        tick();
        checks++;
        if (gear_pos !== 4'd1 || shift_up !== 1'b0) begin
            errors++;
            $display("FAIL gear_after_shift: got gear=%0d up=%0d expected gear=1 up=0",
                     gear_pos, shift_up);
        end
        n = 0;
        while (clutch_req && n < 40) begin
            hi++; n++; tick();
        end
        checks++;
        if (hi !== 12) begin
            errors++; $display("FAIL clutch_req_len: got %0d cycles expected 12", hi);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL release_busy: got %0d expected 1", busy);
        end
        clutch_ack = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL back_to_idle: got busy=%0d expected 0", busy);
        end
        btn_up = 1'b0;
        repeat (10) tick();
    endtask

    task automatic do_shift(input bit up, input logic [3:0] exp, input string name);
        int n;
        if (up) btn_up = 1'b1; else btn_down = 1'b1;
        n = 0;
        while (!clutch_req && n < 20) begin
            tick(); n++;
        end
        checks++;
        if (clutch_req !== 1'b1) begin
            errors++; $display("FAIL %s_req: got clutch_req=%0d expected 1", name, clutch_req);
        end
        tick();
        tick();
        clutch_ack = 1'b1;
        n = 0;
        while (!(shift_up || shift_down) && n < 6) begin
            tick(); n++;
        end
        checks++;
        if ({shift_up, shift_down} !== (up ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL %s_dir: got up/dn=%b expected %b", name, {shift_up, shift_down},
                     up ? 2'b10 : 2'b01);
        end
        n = 0;
        while (clutch_req && n < 20) begin
            tick(); n++;
        end
        clutch_ack = 1'b0;
        n = 0;
        while (busy && n < 5) begin
            tick(); n++;
        end
        btn_up = 1'b0;
        btn_down = 1'b0;
        repeat (10) tick();
        checks++;
        if (gear_pos !== exp || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_gear: got gear=%0d busy=%0d expected gear=%0d busy=0",
                     name, gear_pos, busy, exp);
        end
    endtask

    task automatic test_climb_to_top();
        bit seen;
        do_shift(1'b1, 4'd2, "r_to_n");
        for (int g = 3; g <= 8; g++) begin
            do_shift(1'b1, 4'(g), "upshift");
        end
        seen = 1'b0;
        btn_up = 1'b1;
        repeat (20) begin
            tick();
            if (clutch_req) seen = 1'b1;
        end
        btn_up = 1'b0;
        repeat (10) tick();
        checks++;
        if (seen !== 1'b0 || gear_pos !== 4'd8) begin
            errors++;
            $display("FAIL up_in_g6: got req=%0d gear=%0d expected req=0 gear=8", seen, gear_pos);
        end
        do_shift(1'b0, 4'd7, "g6_down");
    endtask

    task automatic test_timeout();
        int  n;
        bit  seen;
        btn_up = 1'b1;
        n = 0;
        while (!clutch_req && n < 20) begin
            tick(); n++;
        end
        repeat (15) tick();
        checks++;
        if (clutch_req !== 1'b1 || fault !== 1'b0) begin
            errors++;
            $display("FAIL wait_16th: got req=%0d fault=%0d expected req=1 fault=0",
                     clutch_req, fault);
        end
        tick();
        checks++;
        if ({fault, clutch_req, busy} !== 3'b101) begin
            errors++;
            $display("FAIL fault_entry: got fault/req/busy=%b expected 101",
                     {fault, clutch_req, busy});
        end
        btn_up = 1'b0;
        repeat (10) tick();
        seen = 1'b0;
        btn_down = 1'b1;
        repeat (20) begin
            tick();
            if (clutch_req || shift_down || shift_up) seen = 1'b1;
        end
        btn_down = 1'b0;
        checks++;
        if (seen !== 1'b0 || fault !== 1'b1 || gear_pos !== 4'd7) begin
            errors++;
            $display("FAIL fault_sticky: got act=%0d fault=%0d gear=%0d expected 0 1 7",
                     seen, fault, gear_pos);
        end
        reset_n = 1'b0;
        #2;
        checks++;
        if (fault !== 1'b0 || gear_pos !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fault_reset: got fault=%0d gear=%0d busy=%0d expected 0 0 0",
                     fault, gear_pos, busy);
        end
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_bounce();
        int pulses;
        pulses = 0;
        btn_up = 1'b1; tick(); tick();
        btn_up = 1'b0; tick(); tick();
        btn_up = 1'b1;
        repeat (60) begin
            tick();
            if (shift_up) pulses++;
            clutch_ack = clutch_req;
        end
        clutch_ack = 1'b0;
        checks++;
        if (pulses !== 1 || gear_pos !== 4'd1) begin
            errors++;
            $display("FAIL bounce: got pulses=%0d gear=%0d expected 1 1", pulses, gear_pos);
        end
        btn_up = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_both_paddles();
        bit seen;
        seen = 1'b0;
        btn_up = 1'b1;
        btn_down = 1'b1;
        repeat (20) begin
            tick();
            if (clutch_req || busy) seen = 1'b1;
        end
        btn_up = 1'b0;
        btn_down = 1'b0;
        repeat (12) tick();
        checks++;
        if (seen !== 1'b0 || gear_pos !== 4'd1) begin
            errors++;
            $display("FAIL both_paddles: got act=%0d gear=%0d expected 0 1", seen, gear_pos);
        end
    endtask

    task automatic test_reset_in_settle();
        int n;
        btn_up = 1'b1;
        n = 0;
        while (!shift_up && n < 30) begin
            tick(); n++;
            clutch_ack = clutch_req;
        end
        tick();
        tick();
        checks++;
        if ({clutch_req, busy} !== 2'b11 || gear_pos !== 4'd2) begin
            errors++;
            $display("FAIL settle_pre: got req/busy=%b gear=%0d expected 11 2",
                     {clutch_req, busy}, gear_pos);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({clutch_req, busy} !== 2'b00 || gear_pos !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: got req/busy=%b gear=%0d expected 00 0",
                     {clutch_req, busy}, gear_pos);
        end
        btn_up = 1'b0;
        clutch_ack = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_up_without_brake();
        test_first_shift();
        test_climb_to_top();
        test_timeout();
        test_bounce();
        test_both_paddles();
        test_reset_in_settle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
